// File: rtl/level_sequencer.sv
// Game-flow controller for the brick-breaker: level, lives and phase tracking,
// with timed pauses between levels and after a lost ball.
module level_sequencer #(
  parameter int NUM_LEVELS      = 4,
  parameter int LIVES           = 3,
  parameter int PAUSE_CYCLES    = 1_000_000,
  parameter int SPEED_START     = -300,
  parameter int SPEED_STEP      = -50,
  parameter int SPEED_LIMIT     = -500,
  parameter int SMALL_BAT_LEVEL = 2,
  parameter int WRAP            = 0,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_game,
  input  logic               restartGame,
  input  logic               win,
  input  logic               lose,
  output logic [LW-1:0]      choose_brick_matrix,
  output logic [LW-1:0]      level_index,
  output logic signed [31:0] ball_speed,
  output logic               small_bat,
  output logic [3:0]         lives_left,
  output logic               play_enable,
  output logic               load_level,
  output logic               game_over,
  output logic               game_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_LVL_PAUSE,
    S_LIFE_PAUSE,
    S_GAME_OVER,
    S_VICTORY
  } state_t;

  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(PAUSE_CYCLES - 1);
  localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);

  state_t             r_state, w_state;
  logic [LW-1:0]      r_level, w_level;
  logic [3:0]         r_lives, w_lives;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic               w_load;
  logic signed [31:0] r_speed;
  logic               r_small_bat;
  logic               r_play, r_load, r_over, r_won;

  function automatic logic signed [31:0] speed_of(input logic [LW-1:0] lvl);
    int raw;
    raw = SPEED_START + int'(lvl) * SPEED_STEP;
    return (raw < SPEED_LIMIT) ? SPEED_LIMIT : raw;
  endfunction

  function automatic logic small_of(input logic [LW-1:0] lvl);
    return (int'(lvl) >= SMALL_BAT_LEVEL);
  endfunction

  always_comb begin
    w_state = r_state;
    w_level = r_level;
    w_lives = r_lives;
    w_cnt   = r_cnt;
    w_load  = 1'b0;
    if (restartGame) begin
      w_state = S_IDLE;
      w_level = '0;
      w_lives = LIVES_INIT;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_game) begin
            w_state = S_LVL_PAUSE;
            w_level = '0;
            w_lives = LIVES_INIT;
            w_cnt   = CNT_LOAD;
            w_load  = 1'b1;
          end else begin
            w_cnt = '0;
          end
        end
        S_PLAY: begin
          // win takes precedence; a simultaneous lose is dropped
          if (win) begin
            if ((r_level == LAST_LEVEL) && (WRAP == 0)) begin
              w_state = S_VICTORY;
            end else begin
              w_state = S_LVL_PAUSE;
              w_level = (r_level == LAST_LEVEL) ? '0 : r_level + LW'(1);
              w_cnt   = CNT_LOAD;
              w_load  = 1'b1;
            end
          end else if (lose) begin
            if (r_lives > 4'd1) begin
              w_state = S_LIFE_PAUSE;
              w_lives = r_lives - 4'd1;
              w_cnt   = CNT_LOAD;
            end else begin
              w_state = S_GAME_OVER;
              w_lives = 4'd0;
            end
          end else begin
            w_state = S_PLAY;
          end
        end
        S_LVL_PAUSE, S_LIFE_PAUSE: begin
          if (r_cnt == '0) begin
            w_state = S_PLAY;
          end else begin
            w_cnt = r_cnt - CW'(1);
          end
        end
        S_GAME_OVER, S_VICTORY: begin
          w_state = r_state;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_level     <= '0;
      r_lives     <= LIVES_INIT;
      r_cnt       <= '0;
      r_speed     <= speed_of('0);
      r_small_bat <= small_of('0);
      r_play      <= 1'b0;
      r_load      <= 1'b0;
      r_over      <= 1'b0;
      r_won       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_level     <= w_level;
      r_lives     <= w_lives;
      r_cnt       <= w_cnt;
      r_speed     <= speed_of(w_level);
      r_small_bat <= small_of(w_level);
      r_play      <= (w_state == S_PLAY);
      r_load      <= w_load;
      r_over      <= (w_state == S_GAME_OVER);
      r_won       <= (w_state == S_VICTORY);
    end
  end

  assign choose_brick_matrix = r_level;
  assign level_index         = r_level;
  assign ball_speed          = r_speed;
  assign small_bat           = r_small_bat;
  assign lives_left          = r_lives;
  assign play_enable         = r_play;
  assign load_level          = r_load;
  assign game_over           = r_over;
  assign game_won            = r_won;

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Parametrised game-flow controller for the brick-breaker design. Tracks the current level, remaining lives and game phase. Drives the brick-matrix select, ball speed, bat size and a ball-motion enable to the object and physics blocks. Adds over the fixed four-level controller:

- configurable level count, with optional wrap-around;
- a lives counter with game-over;
- timed pauses between levels and after a lost ball;
- a one-cycle brick-matrix reload strobe.

## Interface
- NUM_LEVELS, 4: number of levels, ≥2; LW = $clog2(NUM_LEVELS).
- LIVES, 3: lives at game start, 1..15.
- PAUSE_CYCLES, 1_000_000: length of every pause state in clk cycles, ≥2.
- SPEED_START, -300: ball_speed at level 0 (signed).
- SPEED_STEP, -50: speed added per level index (signed).
- SPEED_LIMIT, -500: clamp bound; ball_speed never goes below it.
- SMALL_BAT_LEVEL, 2: small_bat asserted for level_index ≥ this.
- WRAP, 0: 1 = winning the last level returns to level 0 instead of VICTORY.

- clk  in  1  system clock; the block uses one clock.
- reset  in  1  reset, synchronous and active-high.
- start_game  in  1  pulse; starts a game from IDLE.
- restartGame  in  1  pulse; abort to IDLE from any state.
- win  in  1  pulse; all bricks of the current level cleared.
- lose  in  1  pulse; ball lost.
- choose_brick_matrix  out  LW  brick layout select; equals level_index.
- level_index  out  LW  current level.
- ball_speed  out  32 signed  vertical launch speed for the current level.
- small_bat  out  1  narrow bat select.
- lives_left  out  4  remaining lives.
- play_enable  out  1  ball/bat motion allowed.
- load_level  out  1  one-cycle strobe: reload bricks for level_index.
- game_over  out  1  high in GAME_OVER.
- game_won  out  1  high in VICTORY.

## Operation
- States:
  - IDLE, PLAY, GAME_OVER, VICTORY;
  - LVL_PAUSE (pause before a level starts);
  - LIFE_PAUSE (pause after a lost ball).
- Reset (and restartGame, same behaviour) sets:
  - state IDLE, level_index 0, lives_left LIVES;
  - play_enable 0, load_level 0, game_over 0, game_won 0.
- restartGame has the highest priority in every state, reset excepted.
- IDLE:
  - start_game → LVL_PAUSE, level_index 0, lives_left LIVES, load_level pulsed.
  - All other inputs are ignored.
- PLAY: play_enable = 1.
  - win → LVL_PAUSE with level_index + 1 and load_level pulsed.
  - If level_index = NUM_LEVELS-1 and WRAP = 0, win goes to VICTORY instead (no load_level).
  - If level_index = NUM_LEVELS-1 and WRAP = 1, win goes to LVL_PAUSE with level_index 0 and load_level pulsed; lives are kept.
  - lose with lives_left > 1 → LIFE_PAUSE, lives_left − 1, no load_level (bricks kept).
  - lose with lives_left = 1 → GAME_OVER, lives_left 0.
  - win and lose in the same cycle: win wins; lose is dropped.
- LVL_PAUSE / LIFE_PAUSE:
  - play_enable = 0.
  - Counter loads PAUSE_CYCLES-1 on entry and decrements each cycle; at 0 → PLAY.
  - win, lose and start_game are ignored.
- GAME_OVER / VICTORY:
  - Terminal; exit only via restartGame or reset.
  - win, lose and start_game are ignored.
- ball_speed:
  - Raw value = SPEED_START + level_index·SPEED_STEP, computed in 32-bit signed.
  - If the raw value < SPEED_LIMIT, output SPEED_LIMIT.
  - ball_speed is registered; it updates together with level_index.
- small_bat = (level_index ≥ SMALL_BAT_LEVEL); registered.

## Timing
- All outputs are registered.
- An input sampled at edge N takes effect on the outputs after edge N (cycle N+1). No combinational paths from inputs to outputs.
- load_level is high for exactly the single cycle in which level_index first shows its new value.
- play_enable:
  - Drops in the cycle following the win/lose edge.
  - Is 0 for exactly PAUSE_CYCLES cycles.
  - Rises in the first PLAY cycle.
- Input pulses are assumed one cycle wide. A held input re-triggers only in states that accept it; for example, win held through a pause is seen again in PLAY.
- Reset asserted mid-pause: counter cleared, state IDLE on the next cycle.

## Test plan
- Reset, start_game with PAUSE_CYCLES = 4 → load_level 1 for one cycle, level_index 0, play_enable 0 for 4 cycles then 1, ball_speed −300, lives_left 3.
- Four wins, each after the pause (defaults) → levels 1, 2, 3 with ball_speed −350, −400, −450 and small_bat 0, 1, 1 at levels 1, 2, 3 → fourth win: game_won 1, play_enable 0, no load_level.
- NUM_LEVELS = 8: at level 5 ball_speed clamps to −500; with WRAP = 1, winning level 7 → level_index 0, load_level pulse, lives unchanged.
- Three loses in PLAY → lives_left 2, 1, then game_over 1 with lives_left 0; no load_level on any lose; later win/start_game ignored.
- win and lose on the same edge at level 1, lives 3 → level 2, lives_left stays 3.
- restartGame mid-LIFE_PAUSE, and reset mid-LVL_PAUSE → IDLE next cycle, level 0, lives 3, all strobes 0; no spurious PLAY afterwards.
